dtu_req_sched: RTL and testbench
================================

# dtu_req_sched

Credit-gated round-robin scheduler that shares one bypass descriptor port (`req_t`) between `N_SRC` requesters, for example vFPGA user queues and host-initiated queues. It sits between the per-source request muxes and the bypass read or write queue of the data transfer unit. It bounds each source's outstanding transfers with a per-source credit counter, which completions replenish. It presents one registered descriptor at a time, tagged with the originating source index.

## Interface
Parameters:
- `N_SRC`, 4 — number of requesters, 2..16.
- `MAX_OUTST`, 8 — maximum outstanding descriptors per source, 1..255.
- `SRC_BITS`, `$clog2(N_SRC)` — width of a source index; minimum 1.
- `CRED_BITS`, `$clog2(MAX_OUTST+1)` — width of a credit counter.

Ports:
- `aclk` in 1 — single clock; every port is synchronous to it.
- `areset` in 1 — asynchronous, active-high reset.
- `s_req_valid` in `N_SRC` — per-source descriptor valid.
- `s_req_ready` out `N_SRC` — per-source accept; at most one bit high per cycle.
- `s_req_data` in `N_SRC` x `req_t` — per-source descriptors.
- `src_en` in `N_SRC` — per-source enable; a cleared bit makes that source ineligible.
- `m_req_valid` out 1 — scheduled descriptor valid.
- `m_req_ready` in 1 — downstream accept.
- `m_req_data` out `req_t` — scheduled descriptor.
- `m_req_src` out `SRC_BITS` — index of the source that owns `m_req_data`.
- `cpl_valid` in 1 — completion strobe; returns one credit.
- `cpl_src` in `SRC_BITS` — source index the credit belongs to.
- `cred_avail` out `N_SRC` — per-source flag, high when that source's credit counter is greater than 0.
- `err_cpl` out 1 — sticky error flag; set by an invalid or overflowing completion.

## Operation
- The FSM has two states, ARB and SEND. Reset state is ARB.
- Eligibility: `elig[i] = s_req_valid[i] & src_en[i] & (cred[i] != 0)`.
- ARB state:
  - If `elig` is non-zero, pick the first eligible index scanning from `rr_ptr+1` modulo `N_SRC`.
  - In the same cycle, pulse that source's `s_req_ready` for exactly one cycle.
  - Register `s_req_data[win]` into `m_req_data` and `win` into `m_req_src`.
  - Set `rr_ptr` to `win` and decrement `cred[win]`.
  - Go to SEND.
- If `elig` is zero in ARB, stay in ARB with all `s_req_ready` bits low.
- SEND state:
  - `m_req_valid` is 1.
  - `m_req_data` and `m_req_src` stay stable until `m_req_ready` is sampled high.
  - On that handshake cycle, `m_req_valid` drops the following cycle and the FSM returns to ARB.
- `s_req_ready` is 0 in SEND.
- Credits:
  - `cred[i]` resets to `MAX_OUTST`.
  - A grant decrements it by 1.
  - `cpl_valid` with `cpl_src == i` increments it by 1.
  - A grant and a completion for the same source in the same cycle leave the counter unchanged.
- Invalid completion: if `cpl_src >= N_SRC`, the completion is dropped and `err_cpl` is set.
- Overflow: a completion to a counter already at `MAX_OUTST` is dropped, the counter stays saturated, and `err_cpl` is set.
- `err_cpl` clears only on reset.
- `cred_avail[i]` is a registered copy of `cred[i] != 0`. It reflects credit updates one cycle late.
- Clearing `src_en` affects arbitration only. A descriptor already in SEND still completes its handshake.

## Timing
- Reset values:
  - `m_req_valid` = 0, `s_req_ready` = 0.
  - `m_req_data` = 0, `m_req_src` = 0.
  - `cred_avail` = all ones, `err_cpl` = 0.
  - `rr_ptr` = `N_SRC-1`, so source 0 wins first.
- Reset mid-operation: asserting `areset` while in SEND drops `m_req_valid` immediately and discards the held descriptor. All credits are restored to `MAX_OUTST`.
- Latency: a source's valid is sampled in ARB, and `m_req_valid` rises the next cycle.
- Throughput: at most one descriptor every 2 cycles, even with `m_req_ready` held at 1.
- Round-robin: with every source eligible, grants rotate 0, 1, 2, …, `N_SRC-1`, 0, … with no repeats.
- `s_req_ready` is a combinational function of registered state, `s_req_valid`, `src_en` and credit state. It never depends on `m_req_ready`.

## Configuration
- `DTU_SCHED_STATS_EN` defined:
  - Adds output `stall_cnt[31:0]`, counting cycles with `m_req_valid & !m_req_ready`.
  - Adds output `grant_cnt`, `N_SRC` x 32 bits, with one counter per source that increments on each grant.
  - All counters wrap at 2^32, reset to 0, and clear only on reset.
- `DTU_SCHED_STATS_EN` not defined: these ports and registers do not exist, and behaviour is otherwise identical.

## Test plan
- Reset, then all 4 sources valid with `m_req_ready` = 1 → `m_req_src` sequence 0, 1, 2, 3, 0; one `m_req_valid` every 2 cycles; each `s_req_ready` pulses once per grant.
- `MAX_OUTST` = 2, only source 1 valid, no completions → two grants; `cred_avail[1]` = 0; no further `s_req_ready[1]`. One `cpl_valid` with `cpl_src` = 1 → `cred_avail[1]` = 1 after one cycle, then a third grant follows.
- `m_req_ready` held at 0 for 10 cycles in SEND → `m_req_data` and `m_req_src` stable, all `s_req_ready` = 0; with stats enabled, `stall_cnt` = 10.
- Grant to source 2 and `cpl_valid` with `cpl_src` = 2 in the same cycle → `cred[2]` unchanged. Completion to a full counter → `err_cpl` = 1 and the counter stays at `MAX_OUTST`. `cpl_src` = 5 with `N_SRC` = 4 → `err_cpl` = 1.
- `src_en` = 4'b1011 with all sources valid → source 2 is never granted; grant order is 0, 1, 3, 0.
- `areset` pulsed during SEND with credits partially consumed → `m_req_valid` = 0 immediately, `cred_avail` = 4'hF, and the next grant goes to source 0.

Source files
------------

// File: rtl/dtu_req_sched.sv
`default_nettype none
// ============================================================================
// Module   : dtu_req_sched
// Brief    : Credit-gated round-robin scheduler sharing one bypass descriptor
//            port between N_SRC requesters. Each source owns a credit counter
//            that bounds its outstanding descriptors; completions replenish it.
//            Optional statistics counters are built when DTU_SCHED_STATS_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dtu_req_sched #(
  parameter int N_SRC     = 4,
  parameter int MAX_OUTST = 8,
  parameter int REQ_W     = 64,
  parameter int SRC_BITS  = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  parameter int CRED_BITS = $clog2(MAX_OUTST + 1)
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [N_SRC-1:0]            s_req_valid,
  output logic [N_SRC-1:0]            s_req_ready,
  input  logic [N_SRC-1:0][REQ_W-1:0] s_req_data,
  input  logic [N_SRC-1:0]            src_en,
  output logic                        m_req_valid,
  input  logic                        m_req_ready,
  output logic [REQ_W-1:0]            m_req_data,
  output logic [SRC_BITS-1:0]         m_req_src,
  input  logic                        cpl_valid,
  input  logic [SRC_BITS-1:0]         cpl_src,
  output logic [N_SRC-1:0]            cred_avail,
  output logic                        err_cpl
`ifdef DTU_SCHED_STATS_EN
  ,
  output logic [31:0]                 stall_cnt,
  output logic [N_SRC-1:0][31:0]      grant_cnt
`endif
);

  localparam logic [CRED_BITS-1:0] c_cred_max = CRED_BITS'(MAX_OUTST);
  localparam logic [CRED_BITS-1:0] c_cred_one = CRED_BITS'(1);
  localparam logic [SRC_BITS-1:0]  c_ptr_init = SRC_BITS'(N_SRC - 1);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [SRC_BITS-1:0]             r_rr_ptr;
  logic [REQ_W-1:0]                r_data;
  logic [SRC_BITS-1:0]             r_src;
  logic [N_SRC-1:0][CRED_BITS-1:0] r_cred;
  logic [N_SRC-1:0][CRED_BITS-1:0] w_cred_nxt;
  logic [N_SRC-1:0]                r_cred_avail;
  logic                            r_err;

  logic [N_SRC-1:0]                w_elig;
  logic                            w_found;
  logic [SRC_BITS-1:0]             w_win;
  logic [REQ_W-1:0]                w_win_data;
  logic                            w_grant;
  logic [N_SRC-1:0]                w_gnt;
  logic [N_SRC-1:0]                w_inc;
  logic                            w_err_set;
  int                              w_idx;

  // A source may compete only while it is requesting, enabled and holds credit.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      w_elig[i] = s_req_valid[i] & src_en[i] & (r_cred[i] != '0);
    end
  end

  // Round-robin search starting one past the last winner, wrapping at N_SRC.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % N_SRC;
      for (int j = 0; j < N_SRC; j++) begin
        if (!w_found && (j == w_idx) && w_elig[j]) begin
          w_found = 1'b1;
          w_win   = SRC_BITS'(j);
        end
      end
    end
  end

  // Select the winning descriptor and build the one-hot grant vector.
  always_comb begin
    w_win_data = '0;
    w_gnt      = '0;
    for (int j = 0; j < N_SRC; j++) begin
      if (SRC_BITS'(j) == w_win) begin
        w_win_data = s_req_data[j];
        w_gnt[j]   = w_grant;
      end
    end
  end

  // Next-state logic: grant in ARB when anyone is eligible, hold in SEND until accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (m_req_ready) begin
          w_state_nxt = ST_ARB;
        end
      end
      default: w_state_nxt = ST_ARB;
    endcase
  end

  // State register, round-robin pointer and the held output descriptor.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= ST_ARB;
      r_rr_ptr <= c_ptr_init;
      r_data   <= '0;
      r_src    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_rr_ptr <= w_win;
        r_data   <= w_win_data;
        r_src    <= w_win;
      end
    end
  end

  // Credit bookkeeping: grant and completion on the same source cancel out;
  // a completion into a full counter or for a nonexistent source is an error.
  always_comb begin
    w_err_set = cpl_valid && (int'(cpl_src) >= N_SRC);
    for (int i = 0; i < N_SRC; i++) begin
      w_inc[i]      = cpl_valid && (cpl_src == SRC_BITS'(i));
      w_cred_nxt[i] = r_cred[i];
      if (w_inc[i] && !w_gnt[i]) begin
        if (r_cred[i] == c_cred_max) begin
          w_err_set = 1'b1;
        end else begin
          w_cred_nxt[i] = r_cred[i] + c_cred_one;
        end
      end else if (w_gnt[i] && !w_inc[i]) begin
        w_cred_nxt[i] = r_cred[i] - c_cred_one;
      end
    end
  end

  // Credit counters, the lagging credit-available flags and the sticky error.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_SRC; i++) begin
        r_cred[i] <= c_cred_max;
      end
      r_cred_avail <= '1;
      r_err        <= 1'b0;
    end else begin
      r_cred <= w_cred_nxt;
      for (int i = 0; i < N_SRC; i++) begin
        r_cred_avail[i] <= (r_cred[i] != '0);
      end
      r_err <= r_err | w_err_set;
    end
  end

`ifdef DTU_SCHED_STATS_EN
  logic [31:0]            r_stall_cnt;
  logic [N_SRC-1:0][31:0] r_grant_cnt;

  // Free-running wrap-around statistics: stalled output cycles and per-source grants.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_stall_cnt <= '0;
      r_grant_cnt <= '0;
    end else begin
      if ((r_state == ST_SEND) && !m_req_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      for (int i = 0; i < N_SRC; i++) begin
        if (w_gnt[i]) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign grant_cnt = r_grant_cnt;
`endif

  // Accept pulses are held low while reset is asserted.
  assign s_req_ready = areset ? '0 : w_gnt;
  assign m_req_valid = (r_state == ST_SEND);
  assign m_req_data  = r_data;
  assign m_req_src   = r_src;
  assign cred_avail  = r_cred_avail;
  assign err_cpl     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dtu_req_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dtu_req_sched
// Brief    : Scoreboard bench for dtu_req_sched (N_SRC=4, MAX_OUTST=2, 3-bit
//            source index so out-of-range completions can be driven).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dtu_req_sched;

  localparam int N     = 4;
  localparam int SB    = 3;
  localparam int DW    = 32;

  logic              aclk = 1'b0;
  logic              areset;
  logic [N-1:0]      s_req_valid;
  logic [N-1:0]      s_req_ready;
  logic [N-1:0][DW-1:0] s_req_data;
  logic [N-1:0]      src_en;
  logic              m_req_valid;
  logic              m_req_ready;
  logic [DW-1:0]     m_req_data;
  logic [SB-1:0]     m_req_src;
  logic              cpl_valid;
  logic [SB-1:0]     cpl_src;
  logic [N-1:0]      cred_avail;
  logic              err_cpl;
`ifdef DTU_SCHED_STATS_EN
  logic [31:0]       stall_cnt;
  logic [N-1:0][31:0] grant_cnt;
`endif

  dtu_req_sched #(
    .N_SRC(N), .MAX_OUTST(2), .REQ_W(DW), .SRC_BITS(SB)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
    .src_en(src_en),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_data(m_req_data), .m_req_src(m_req_src),
    .cpl_valid(cpl_valid), .cpl_src(cpl_src),
    .cred_avail(cred_avail), .err_cpl(err_cpl)
`ifdef DTU_SCHED_STATS_EN
    , .stall_cnt(stall_cnt), .grant_cnt(grant_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [SB-1:0] src;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [DW-1:0] dat(int s);
    return 32'hC0DE_0000 + 32'(s) * 32'h0000_0111;
  endfunction

  task automatic push(int s);
    exp_t t;
    t.src  = SB'(s);
    t.data = dat(s);
    q.push_back(t);
  endtask

  // Output scoreboard: every accepted descriptor must match the next expectation.
  always @(negedge aclk) begin
    if (!areset && m_req_valid && m_req_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out src=%0d data=%h (nothing expected)", m_req_src, m_req_data);
      end else begin
        mon_e = q.pop_front();
        if (m_req_src !== mon_e.src || m_req_data !== mon_e.data) begin
          bad++;
          $display("FAIL out_order got src=%0d data=%h want src=%0d data=%h",
                   m_req_src, m_req_data, mon_e.src, mon_e.data);
        end
      end
    end
  end

  task automatic idle_inputs();
    s_req_valid = '0;
    src_en      = '1;
    m_req_ready = 1'b0;
    cpl_valid   = 1'b0;
    cpl_src     = '0;
    for (int i = 0; i < N; i++) s_req_data[i] = dat(i);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    idle_inputs();
    q.delete();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge aclk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain left=%0d want 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    idle_inputs();
    @(negedge aclk);
    total++; if (m_req_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", m_req_valid); end
    total++; if (s_req_ready !== 4'h0) begin bad++; $display("FAIL rst_ready got %b want 0000", s_req_ready); end
    total++; if (m_req_data !== 32'h0) begin bad++; $display("FAIL rst_data got %h want 0", m_req_data); end
    total++; if (m_req_src !== 3'd0) begin bad++; $display("FAIL rst_src got %0d want 0", m_req_src); end
    total++; if (cred_avail !== 4'hF) begin bad++; $display("FAIL rst_cred got %b want 1111", cred_avail); end
    total++; if (err_cpl !== 1'b0) begin bad++; $display("FAIL rst_err got %b want 0", err_cpl); end
    @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_rdy;
    do_reset();
    s_req_valid = '1;
    m_req_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(seq[i]);
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      exp_rdy = (c % 2 == 0) ? (4'b0001 << seq[c/2]) : 4'b0000;
      total++;
      if (s_req_ready !== exp_rdy) begin
        bad++; $display("FAIL rr_ready c=%0d got %b want %b", c, s_req_ready, exp_rdy);
      end
      total++;
      if (m_req_valid !== (c % 2 == 1)) begin
        bad++; $display("FAIL rr_valid c=%0d got %b want %b", c, m_req_valid, (c % 2 == 1));
      end
    end
    @(posedge aclk);
    #1 s_req_valid = '0;
    drain("rr");
  endtask

  task automatic test_credit();
    int n = 0;
    do_reset();
    s_req_valid = 4'b0010;
    m_req_ready = 1'b1;
    push(1); push(1);
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      if (s_req_ready[1]) n++;
    end
    total++; if (n != 2) begin bad++; $display("FAIL cred_grants got %0d want 2", n); end
    total++; if (cred_avail !== 4'b1101) begin bad++; $display("FAIL cred_empty got %b want 1101", cred_avail); end
    total++; if (err_cpl !== 1'b0) begin bad++; $display("FAIL cred_err got %b want 0", err_cpl); end
    push(1);
    @(posedge aclk);
    #1 cpl_valid = 1'b1; cpl_src = 3'd1;
    @(negedge aclk);
    total++; if (cred_avail[1] !== 1'b0) begin bad++; $display("FAIL cred_lag got %b want 0", cred_avail[1]); end
    @(posedge aclk);
    #1 cpl_valid = 1'b0;
    @(negedge aclk);
    total++; if (s_req_ready !== 4'b0010) begin bad++; $display("FAIL cred_regrant got %b want 0010", s_req_ready); end
    @(negedge aclk);
    total++; if (cred_avail[1] !== 1'b1) begin bad++; $display("FAIL cred_avail_back got %b want 1", cred_avail[1]); end
    @(posedge aclk);
    #1 s_req_valid = '0;
    drain("cred");
  endtask

  task automatic test_stall();
    do_reset();
    s_req_valid = '1;
    m_req_ready = 1'b0;
    push(0);
    @(negedge aclk);
    total++; if (s_req_ready !== 4'b0001) begin bad++; $display("FAIL stall_grant got %b want 0001", s_req_ready); end
    @(posedge aclk);
    #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      total++;
      if (m_req_valid !== 1'b1 || m_req_src !== 3'd0 || m_req_data !== dat(0) || s_req_ready !== 4'b0000) begin
        bad++;
        $display("FAIL stall_hold c=%0d got v=%b src=%0d data=%h rdy=%b want v=1 src=0 data=%h rdy=0000",
                 c, m_req_valid, m_req_src, m_req_data, s_req_ready, dat(0));
      end
      @(posedge aclk);
      #1;
    end
    m_req_ready = 1'b1;
    s_req_valid = '0;
`ifdef DTU_SCHED_STATS_EN
    @(negedge aclk);
    total++; if (stall_cnt !== 32'd10) begin bad++; $display("FAIL stall_cnt got %0d want 10", stall_cnt); end
    total++; if (grant_cnt[0] !== 32'd1) begin bad++; $display("FAIL grant_cnt0 got %0d want 1", grant_cnt[0]); end
`endif
    drain("stall");
  endtask

  task automatic test_same_cycle();
    int n = 0;
    do_reset();
    s_req_valid = 4'b0100;
    m_req_ready = 1'b1;
    cpl_valid   = 1'b1;
    cpl_src     = 3'd2;
    push(2); push(2); push(2);
    @(negedge aclk);
    if (s_req_ready[2]) n++;
    @(posedge aclk);
    #1 cpl_valid = 1'b0;
    for (int c = 0; c < 11; c++) begin
      @(negedge aclk);
      if (s_req_ready[2]) n++;
    end
    total++; if (n != 3) begin bad++; $display("FAIL same_cycle_grants got %0d want 3", n); end
    total++; if (err_cpl !== 1'b0) begin bad++; $display("FAIL same_cycle_err got %b want 0", err_cpl); end
    @(posedge aclk);
    #1 s_req_valid = '0;
    drain("same");
  endtask

  task automatic test_overflow();
    int n = 0;
    do_reset();
    cpl_valid = 1'b1;
    cpl_src   = 3'd0;
    @(negedge aclk);
    total++; if (err_cpl !== 1'b0) begin bad++; $display("FAIL ovf_pre got %b want 0", err_cpl); end
    @(posedge aclk);
    #1 cpl_valid = 1'b0;
    @(negedge aclk);
    total++; if (err_cpl !== 1'b1) begin bad++; $display("FAIL ovf_err got %b want 1", err_cpl); end
    @(posedge aclk);
    #1 s_req_valid = 4'b0001; m_req_ready = 1'b1;
    push(0); push(0);
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (s_req_ready[0]) n++;
    end
    total++; if (n != 2) begin bad++; $display("FAIL ovf_saturate grants got %0d want 2", n); end
    total++; if (err_cpl !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %b want 1", err_cpl); end
    @(posedge aclk);
    #1 s_req_valid = '0;
    drain("ovf");
  endtask

  task automatic test_bad_src();
    do_reset();
    cpl_valid = 1'b1;
    cpl_src   = 3'd5;
    @(negedge aclk);
    total++; if (err_cpl !== 1'b0) begin bad++; $display("FAIL badsrc_pre got %b want 0", err_cpl); end
    @(posedge aclk);
    #1 cpl_valid = 1'b0;
    @(negedge aclk);
    total++; if (err_cpl !== 1'b1) begin bad++; $display("FAIL badsrc_err got %b want 1", err_cpl); end
    total++; if (cred_avail !== 4'hF) begin bad++; $display("FAIL badsrc_cred got %b want 1111", cred_avail); end
  endtask

  task automatic test_src_en();
    int n2 = 0;
    do_reset();
    src_en      = 4'b1011;
    s_req_valid = '1;
    m_req_ready = 1'b1;
    push(0); push(1); push(3); push(0);
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      if (s_req_ready[2]) n2++;
    end
    total++; if (n2 != 0) begin bad++; $display("FAIL src_en_block got %0d grants to 2 want 0", n2); end
    @(posedge aclk);
    #1 s_req_valid = '0; src_en = '1;
    drain("src_en");
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_req_valid = '1;
    m_req_ready = 1'b1;
    push(0); push(1);
    for (int c = 0; c < 4; c++) begin
      @(negedge aclk);
    end
    @(posedge aclk);
    #1 m_req_ready = 1'b0;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    total++; if (m_req_valid !== 1'b1 || m_req_src !== 3'd2) begin
      bad++; $display("FAIL mid_send got v=%b src=%0d want v=1 src=2", m_req_valid, m_req_src);
    end
    @(posedge aclk);
    #1 areset = 1'b1;
    #1;
    total++; if (m_req_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got %b want 0", m_req_valid); end
    total++; if (cred_avail !== 4'hF) begin bad++; $display("FAIL mid_cred got %b want 1111", cred_avail); end
    @(posedge aclk);
    #1 areset = 1'b0; m_req_ready = 1'b1;
    push(0);
    @(negedge aclk);
    total++; if (s_req_ready !== 4'b0001) begin bad++; $display("FAIL mid_next got %b want 0001", s_req_ready); end
    @(posedge aclk);
    #1 s_req_valid = '0;
    drain("mid");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_credit();
    test_stall();
    test_same_cycle();
    test_overflow();
    test_bad_src();
    test_src_en();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
